// File: rtl/comparator_pkg.sv
// Shared definitions for the bit-serial comparator: relation select codes,
// FSM state encoding and the relation evaluation helper.
package comparator_pkg;

    localparam logic [1:0] MODE_EQ = 2'b00;
    localparam logic [1:0] MODE_NE = 2'b01;
    localparam logic [1:0] MODE_LT = 2'b10;
    localparam logic [1:0] MODE_GT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SCAN = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // lt is implied by found & !gt, since gt records a at the first differing bit
    function automatic logic rel_result(input logic [1:0] mode,
                                        input logic       found,
                                        input logic       gt);
        logic r;
        r = 1'b0;
        case (mode)
            MODE_EQ: r = ~found;
            MODE_NE: r = found;
            MODE_LT: r = found & ~gt;
            MODE_GT: r = found & gt;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/serial_comparator_bit_diff.sv
// Single-bit difference cell used by the serial comparator scan stage.
module bit_diff (
    input  logic a,
    input  logic b,
    output logic s
);

    assign s = a ^ b;

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial MSB-first comparator with start/busy/done handshake, selectable
// EQ/NE/LT/GT relation and a per-bit difference mask of the scanned bits.
module serial_comparator
    import comparator_pkg::*;
#(
    parameter int unsigned WIDTH      = 5,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic [WIDTH-1:0] diff
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             state_n;
    logic [WIDTH-1:0]   a_l;
    logic [WIDTH-1:0]   b_l;
    logic [1:0]         mode_l;
    logic [IDX_W-1:0]   idx;
    logic               found;
    logic               gt;

    logic               bit_a;
    logic               bit_b;
    logic               bit_s;
    logic               first_hit;
    logic               found_n;
    logic               gt_n;
    logic               scan_last;

    assign bit_a = a_l[idx];
    assign bit_b = b_l[idx];

    bit_diff u_bit_diff (
        .a (bit_a),
        .b (bit_b),
        .s (bit_s)
    );

    // Relation flags as they will stand after the current scan edge
    always_comb begin
        first_hit = bit_s & ~found;
        found_n   = found | bit_s;
        gt_n      = first_hit ? bit_a : gt;
        scan_last = (idx == '0) || (EARLY_EXIT && first_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_SCAN;
            S_SCAN:  if (scan_last) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs follow the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            a_l    <= '0;
            b_l    <= '0;
            mode_l <= '0;
            idx    <= '0;
            found  <= 1'b0;
            gt     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 1'b0;
            diff   <= '0;
        end else begin
            busy <= (state_n == S_SCAN);
            done <= (state_n == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_l    <= a;
                        b_l    <= b;
                        mode_l <= mode;
                        idx    <= IDX_W'(WIDTH - 1);
                        found  <= 1'b0;
                        gt     <= 1'b0;
                        result <= 1'b0;
                        diff   <= '0;
                    end
                end
                S_SCAN: begin
                    diff[idx] <= bit_s;
                    found     <= found_n;
                    gt        <= gt_n;
                    if (scan_last) begin
                        result <= rel_result(mode_l, found_n, gt_n);
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Directed self-checking bench for serial_comparator: three instances cover
// WIDTH=5 early-exit, WIDTH=5 full-scan and WIDTH=8 full-scan configurations.
module tb_serial_comparator;

    logic       clk;
    logic       reset;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       start0, start1, start2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic       res0, res1, res2;
    logic [4:0] diff0, diff1;
    logic [7:0] diff2;

    int         sel;
    logic       s_busy, s_done, s_res;
    logic [7:0] s_diff;

    int total;
    int bad;

    serial_comparator #(.WIDTH(5), .EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .reset(reset), .start(start0), .mode(mode),
        .a(a[4:0]), .b(b[4:0]), .busy(busy0), .done(done0),
        .result(res0), .diff(diff0)
    );

    serial_comparator #(.WIDTH(5), .EARLY_EXIT(1'b0)) dut_full (
        .clk(clk), .reset(reset), .start(start1), .mode(mode),
        .a(a[4:0]), .b(b[4:0]), .busy(busy1), .done(done1),
        .result(res1), .diff(diff1)
    );

    serial_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_wide (
        .clk(clk), .reset(reset), .start(start2), .mode(mode),
        .a(a), .b(b), .busy(busy2), .done(done2),
        .result(res2), .diff(diff2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        s_busy = busy0;
        s_done = done0;
        s_res  = res0;
        s_diff = {3'b000, diff0};
        case (sel)
            1: begin s_busy = busy1; s_done = done1; s_res = res1; s_diff = {3'b000, diff1}; end
            2: begin s_busy = busy2; s_done = done2; s_res = res2; s_diff = diff2; end
            default: ;
        endcase
    end

    task automatic set_start(input logic v);
        start0 = (sel == 0) ? v : 1'b0;
        start1 = (sel == 1) ? v : 1'b0;
        start2 = (sel == 2) ? v : 1'b0;
    endtask

    // Present a request before edge 0, release it after; returns sampled busy
    task automatic launch(input logic [7:0] av, input logic [7:0] bv,
                          input logic [1:0] m, output logic busy_after);
        @(negedge clk);
        a = av; b = bv; mode = m;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        busy_after = s_busy;
    endtask

    // Edges after edge 0 until done is seen; -1 if the budget expires
    task automatic wait_done(output int edges);
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (s_done) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            total++;
            if ({s_busy, s_done, s_res, s_diff} !== 11'd0) begin
                bad++;
                $display("FAIL reset_outputs dut%0d: busy=%b done=%b result=%b diff=%h, want all 0",
                         i, s_busy, s_done, s_res, s_diff);
            end
        end
        reset = 1'b0;
        sel = 0;
    endtask

    task automatic test_equal;
        logic bz;
        int   e;
        sel = 0;
        launch(8'b10101, 8'b10101, 2'b00, bz);
        total++;
        if (bz !== 1'b1) begin bad++; $display("FAIL eq_busy: got %b want 1", bz); end
        wait_done(e);
        total++;
        if (e !== 5) begin bad++; $display("FAIL eq_latency: got %0d want 5", e); end
        total++;
        if (s_res !== 1'b1 || s_diff !== 8'h00 || s_busy !== 1'b0) begin
            bad++;
            $display("FAIL eq_result: result=%b diff=%h busy=%b want 1 00 0", s_res, s_diff, s_busy);
        end
        @(negedge clk);
        total++;
        if (s_done !== 1'b0 || s_res !== 1'b1) begin
            bad++;
            $display("FAIL eq_pulse: done=%b result=%b want 0 1", s_done, s_res);
        end
    endtask

    task automatic test_lsb_diff;
        logic [1:0] modes [3];
        logic       exp_r [3];
        logic       bz;
        int         e;
        modes = '{2'b01, 2'b11, 2'b10};
        exp_r = '{1'b1, 1'b1, 1'b0};
        sel = 0;
        for (int i = 0; i < 3; i++) begin
            launch(8'b10011, 8'b10010, modes[i], bz);
            wait_done(e);
            total++;
            if (e !== 5 || s_res !== exp_r[i] || s_diff !== 8'b00001) begin
                bad++;
                $display("FAIL lsb_diff mode=%b: edges=%0d result=%b diff=%b want 5 %b 00001",
                         modes[i], e, s_res, s_diff[4:0], exp_r[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_early_exit;
        logic bz;
        int   e;
        sel = 0;
        launch(8'b10101, 8'b00101, 2'b11, bz);
        wait_done(e);
        total++;
        if (e !== 1 || s_res !== 1'b1 || s_diff !== 8'b10000) begin
            bad++;
            $display("FAIL early_exit: edges=%0d result=%b diff=%b want 1 1 10000", e, s_res, s_diff[4:0]);
        end
        @(negedge clk);
        sel = 1;
        launch(8'b10101, 8'b00101, 2'b11, bz);
        wait_done(e);
        total++;
        if (e !== 5 || s_res !== 1'b1 || s_diff !== 8'b10000) begin
            bad++;
            $display("FAIL full_scan: edges=%0d result=%b diff=%b want 5 1 10000", e, s_res, s_diff[4:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore;
        logic bz;
        int   pulses;
        sel = 0;
        launch(8'b00111, 8'b01000, 2'b10, bz);
        // Re-request with different operands while scanning
        a = 8'b11111; b = 8'b00000; mode = 2'b00;
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        pulses = s_done ? 1 : 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (s_done) pulses++;
        end
        total++;
        if (pulses !== 1) begin bad++; $display("FAIL busy_ignore_pulses: got %0d want 1", pulses); end
        total++;
        if (s_res !== 1'b1 || s_diff !== 8'b01000 || s_busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore_hold: result=%b diff=%b busy=%b want 1 01000 0",
                     s_res, s_diff[4:0], s_busy);
        end
    endtask

    task automatic test_reset_mid;
        logic bz;
        int   pulses;
        int   e;
        sel = 1;
        launch(8'b01010, 8'b00101, 2'b11, bz);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({s_busy, s_done, s_res, s_diff} !== 11'd0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b result=%b diff=%b want all 0",
                     s_busy, s_done, s_res, s_diff[4:0]);
        end
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (s_done || s_busy) pulses++;
        end
        total++;
        if (pulses !== 0) begin bad++; $display("FAIL reset_mid_quiet: activity=%0d want 0", pulses); end
        launch(8'b01010, 8'b00101, 2'b11, bz);
        wait_done(e);
        total++;
        if (e !== 5 || s_res !== 1'b1 || s_diff !== 8'b01111) begin
            bad++;
            $display("FAIL reset_mid_restart: edges=%0d result=%b diff=%b want 5 1 01111",
                     e, s_res, s_diff[4:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_wide;
        logic bz;
        int   e;
        sel = 2;
        launch(8'hFF, 8'h00, 2'b01, bz);
        wait_done(e);
        total++;
        if (e !== 8 || s_res !== 1'b1 || s_diff !== 8'hFF) begin
            bad++;
            $display("FAIL wide_ne: edges=%0d result=%b diff=%h want 8 1 ff", e, s_res, s_diff);
        end
        launch(8'h5A, 8'h5A, 2'b01, bz);
        wait_done(e);
        total++;
        if (e !== 8 || s_res !== 1'b0 || s_diff !== 8'h00) begin
            bad++;
            $display("FAIL wide_eq_ne: edges=%0d result=%b diff=%h want 8 0 00", e, s_res, s_diff);
        end
        @(negedge clk);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        sel    = 0;
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        mode   = 2'b00;
        a      = 8'h00;
        b      = 8'h00;
        test_reset;
        test_equal;
        test_lsb_diff;
        test_early_exit;
        test_busy_ignore;
        test_reset_mid;
        test_wide;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_comparator.md
Name: serial_comparator

Overview:
- Bit-serial, parametrised comparator; successor to the fixed 5-bit combinational XOR inequality test.
- Takes two WIDTH-bit unsigned operands and scans them MSB-first, one bit per clock.
- Produces a selectable relation (EQ / NE / LT / GT) plus a per-bit difference mask.
- Sits beside the ALU as a low-area compare unit, driven by a start/busy/done handshake.

Parameters:
- WIDTH, 5, operand width in bits; legal range 1..32.
- EARLY_EXIT, 1, 1 = stop scanning at the first differing bit; 0 = always scan all WIDTH bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  2  relation select, sampled with start: 00 EQ, 01 NE, 10 LT (a<b), 11 GT (a>b).
- a  input  WIDTH  operand A, latched on the accepted start.
- b  input  WIDTH  operand B, latched on the accepted start.
- busy  output  1  high while a compare is in progress (SCAN).
- done  output  1  one-cycle pulse; result and diff are valid in that cycle.
- result  output  1  relation outcome; held until the next accepted start.
- diff  output  WIDTH  per-bit mask of a XOR b for the bits scanned; held like result.

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset, including mid-operation: on the next edge, state goes to IDLE and busy, done, result and diff all go to 0. Latched operands, mode, bit index and relation flags are cleared. No done pulse is issued for an aborted compare.
- States: IDLE, SCAN, DONE.
- IDLE:
  - If start=1 at an edge, latch a, b and mode, set idx = WIDTH-1, clear result, diff and relation flags, then go to SCAN.
  - busy=1 from that edge onward.
- SCAN (one bit per edge):
  - diff[idx] <= a_l[idx] ^ b_l[idx].
  - On the first differing bit, record gt = a_l[idx] (so lt = b_l[idx]) and set found=1.
  - Exit to DONE when idx==0, or when EARLY_EXIT=1 and a difference was just found. Otherwise idx <= idx-1.
- DONE:
  - busy=0, done=1 for exactly one cycle.
  - result = !found for EQ, found for NE, found&lt for LT, found&gt for GT.
  - Next edge: go to IDLE with done=0; result and diff keep their values.
- Latency: with start sampled at edge 0, bit WIDTH-1 is processed at edge 1 and bit i at edge WIDTH-i.
  - EARLY_EXIT=0: always WIDTH scan edges; done is high in the cycle after edge WIDTH.
  - EARLY_EXIT=1: the scan ends at the edge that processes the first differing bit; equal operands still take WIDTH edges.
- With EARLY_EXIT=1, diff bits below the first difference stay 0 (never scanned).
- start while busy=1 or in DONE is ignored; no queueing. The caller must re-assert start in IDLE.
- Operand or mode changes after acceptance have no effect on the running compare.
- WIDTH=1: SCAN lasts one edge.
- idx width is $clog2(WIDTH), minimum 1. Counting down from 0 never occurs because exit is forced at idx==0.

Decomposition:
- Shared package comparator_pkg holds:
  - mode constants MODE_EQ=2'b00, MODE_NE=2'b01, MODE_LT=2'b10, MODE_GT=2'b11;
  - state encoding S_IDLE, S_SCAN, S_DONE (2-bit).
- One natural sub-module, bit_diff: a single-bit XOR difference cell (output s; inputs a, b). SCAN instantiates it on the selected bit pair.
- The FSM, index counter and result logic stay in serial_comparator.

Test Plan:
- WIDTH=5, EARLY_EXIT=1, a=10101, b=10101, mode=EQ, start at edge 0 -> busy over edges 1..5, done in the cycle after edge 5, result=1, diff=00000.
- a=10011, b=10010, mode=NE -> first difference at bit 0, done after edge 5, result=1, diff=00001. Repeating with mode=GT gives result=1; mode=LT gives result=0.
- EARLY_EXIT=1, a=10101, b=00101, mode=GT -> done after edge 1, result=1, diff=10000. With EARLY_EXIT=0, same operands -> done after edge 5, diff=10000, result=1.
- a=00111, b=01000, mode=LT -> result=1. Pulse start again while busy -> ignored; exactly one done pulse, and result holds after returning to IDLE.
- Assert reset at edge 2 of a scan -> next cycle busy=0, done=0, result=0, diff=0, state IDLE, no done pulse. A new start then completes normally.
- WIDTH=8, EARLY_EXIT=0, a=0xFF, b=0x00, mode=NE -> done after edge 8, diff=0xFF, result=1.
